// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
//
// Two-entry skid buffer placed between adjacent pipeline stages (for example
// IF->ID or ID->EX). Both sides use a valid/ready handshake. Every handshake
// output is a flop, so there is no combinational path from out_ready to
// in_ready. The head entry lives in the main register, which drives out_data
// directly. A second (skid) register absorbs the one payload that can arrive
// in the cycle in which downstream stalls.
//
// Parameters:
//   DATA_LEN  payload width in bits
//   RST_DATA  value loaded into both payload registers on reset
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   flush      discard all buffered entries this cycle (branch/exception redirect)
//   in_valid   upstream offers a payload
//   in_ready   buffer can accept a payload (registered)
//   in_data    upstream payload
//   out_valid  buffer holds a payload for downstream (registered)
//   out_ready  downstream accepts the payload
//   out_data   head payload (main register)
//   count      occupancy: 0, 1 or 2 (registered)
//
// Priority at each edge: reset > flush > normal handshake.
// -----------------------------------------------------------------------------
module pipe_skid_buf #(
    parameter int unsigned          DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0]  RST_DATA = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_data,
    output logic [1:0]          count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_LEN-1:0]   r_main;
    logic [DATA_LEN-1:0]   w_main_nxt;
    logic [DATA_LEN-1:0]   r_skid;
    logic [DATA_LEN-1:0]   w_skid_nxt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [1:0]            r_count;
    logic [1:0]            w_count_nxt;
    logic                  w_push;
    logic                  w_pop;

    // Handshake qualifiers. Both use only registered outputs of this block,
    // so in_ready never depends combinationally on out_ready.
    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    // Next-state and next-payload selection for the occupancy FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            // Payload registers keep their contents; only occupancy is
            // cleared. A same-cycle push is dropped. A same-cycle pop has
            // already been consumed downstream.
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = in_data;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = in_data;
                    end else if (w_push) begin
                        // Head is stalled, so the new arrival parks in skid.
                        w_state_nxt = ST_TWO;
                        w_skid_nxt  = in_data;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can change anything.
                    if (w_pop) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                    end else begin
                        w_state_nxt = ST_TWO;
                    end
                end
                default: begin
                    // An illegal encoding recovers to empty.
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy encoding of the next state. It feeds the registered count.
    always_comb begin
        w_count_nxt = 2'd0;
        case (w_state_nxt)
            ST_EMPTY: w_count_nxt = 2'd0;
            ST_ONE:   w_count_nxt = 2'd1;
            ST_TWO:   w_count_nxt = 2'd2;
            default:  w_count_nxt = 2'd0;
        endcase
    end

    // State, payload and registered handshake outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_main      <= RST_DATA;
            r_skid      <= RST_DATA;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_count     <= w_count_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign count     = r_count;

endmodule

// File: tb/tb_pipe_skid_buf.sv
module tb_pipe_skid_buf;

    localparam int unsigned DATA_LEN = 32;

    logic                clk;
    logic                rst_n;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] out_data;
    logic [1:0]          count;

    int n_checks;
    int n_fail;

    pipe_skid_buf #(
        .DATA_LEN (DATA_LEN),
        .RST_DATA (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic ir,
                           input logic [1:0] cnt, input logic [31:0] od);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir});
        chk({tag, ".count"},     {30'd0, count},     {30'd0, cnt});
        chk({tag, ".out_data"},  out_data,           od);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 32'h0;

        // Reset held for two cycles
        step();
        chk_all("rst1", 1'b0, 1'b0, 2'd0, 32'h0);
        step();
        chk_all("rst2", 1'b0, 1'b0, 2'd0, 32'h0);
        rst_n = 1'b1;
        step();
        chk_all("rel", 1'b0, 1'b1, 2'd0, 32'h0);

        // Streaming with downstream always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        chk_all("str11", 1'b1, 1'b1, 2'd1, 32'h11);
        in_data = 32'h22;
        step();
        chk_all("str22", 1'b1, 1'b1, 2'd1, 32'h22);
        in_data = 32'h33;
        step();
        chk_all("str33", 1'b1, 1'b1, 2'd1, 32'h33);
        in_valid = 1'b0;
        step();
        chk_all("strdrain", 1'b0, 1'b1, 2'd0, 32'h33);

        // Backpressure fills both entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA1;
        step();
        chk_all("bpA1", 1'b1, 1'b1, 2'd1, 32'hA1);
        in_data = 32'hA2;
        step();
        chk_all("bpA2", 1'b1, 1'b0, 2'd2, 32'hA1);
        in_data = 32'hA3;
        step();
        chk_all("bpA3rej", 1'b1, 1'b0, 2'd2, 32'hA1);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        chk_all("bppopA1", 1'b1, 1'b1, 2'd1, 32'hA2);
        in_valid = 1'b1;
        in_data  = 32'hA3;
        step();
        chk_all("bpA3", 1'b1, 1'b1, 2'd1, 32'hA3);
        in_valid = 1'b0;
        step();
        chk_all("bpdrain", 1'b0, 1'b1, 2'd0, 32'hA3);

        // Flush while full, with a push offered in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hB1;
        step();
        in_data = 32'hB2;
        step();
        chk_all("flfull", 1'b1, 1'b0, 2'd2, 32'hB1);
        flush   = 1'b1;
        in_data = 32'hB3;
        step();
        chk_all("flush", 1'b0, 1'b1, 2'd0, 32'hB1);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk_all("flpost", 1'b0, 1'b1, 2'd0, 32'hB1);

        // Simultaneous push and pop while holding one entry
        in_valid = 1'b1;
        in_data  = 32'hC1;
        step();
        chk_all("ppC1", 1'b1, 1'b1, 2'd1, 32'hC1);
        in_data   = 32'hC2;
        out_ready = 1'b1;
        step();
        chk_all("ppC2", 1'b1, 1'b1, 2'd1, 32'hC2);

        // Reset mid-operation while full
        out_ready = 1'b0;
        in_data   = 32'hD1;
        step();
        chk_all("mrfull", 1'b1, 1'b0, 2'd2, 32'hC2);
        rst_n = 1'b0;
        step();
        chk_all("mrst", 1'b0, 1'b0, 2'd0, 32'h0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        chk_all("mrrel", 1'b0, 1'b1, 2'd0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
